ex_core_ram_bist: RTL and testbench
===================================

# ex_core_ram_bist

Parametrised successor to the embedded-core RAM used as the IEEE 1500 wrapped core. It provides a single-port synchronous RAM with configurable data width, address width and depth, a registered read path with a data-valid strobe, and defined behaviour on read/write collisions. It adds a built-in March C- self-test engine so the wrapper can run memory BIST through a start/busy/done/fail handshake.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (at least 1).
- ADDR_W, 6, address bus width.
- DEPTH, 64, number of implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_W.

Ports:
- CLK  in  1  single clock; all logic updates on the rising edge.
- CoreIN_RESET  in  1  synchronous, active-high reset.
- CoreIN_RX  in  1  read request.
- CoreIN_TX  in  1  write request.
- CoreIN_ADDR  in  ADDR_W  word address.
- CoreIN_DIN  in  DATA_W  write data.
- CoreIN_DOUT  out  DATA_W  registered read data.
- CoreIN_DVALID  out  1  one-cycle pulse when CoreIN_DOUT is updated by a read.
- CoreIN_ERR  out  1  one-cycle pulse on a collision or out-of-range access.
- BIST_START  in  1  starts March C- when sampled high in IDLE.
- BIST_INJ  in  1  fault injection for DFT validation: stuck-at-0 on bit 0 of address 0 during BIST writes.
- BIST_BUSY  out  1  high while the test runs.
- BIST_DONE  out  1  level; test completed.
- BIST_FAIL  out  1  sticky; at least one mismatch.
- BIST_FAIL_ADDR  out  ADDR_W  address of the first mismatch.

## Operation
- Reset, at the rising edge with CoreIN_RESET=1:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Memory contents are not cleared and are undefined until written.
- Functional mode (FSM in IDLE or DONE):
  - Write: TX=1, RX=0, ADDR<DEPTH. mem[ADDR] <= DIN.
  - Read: RX=1, TX=0, ADDR<DEPTH. DOUT <= mem[ADDR] and DVALID=1 for one cycle.
  - Collision: RX=TX=1. No access, DOUT holds, ERR pulses.
  - Out of range: ADDR>=DEPTH with RX or TX high. No access, ERR pulses, DVALID stays 0.
- FSM states and transitions:
  - IDLE: START=1 goes to RUN.
  - RUN: after the last element goes to FLUSH.
  - FLUSH: goes to DONE.
  - DONE: START=1 goes to RUN, which clears DONE, FAIL and FAIL_ADDR. Otherwise DONE holds.
- March C- sequence, one read or write per cycle. Background B0 is all zeros; B1 is all ones of DATA_W.
  - E0: up, w B0.
  - E1: up, (r B0, w B1).
  - E2: up, (r B1, w B0).
  - E3: down, (r B0, w B1).
  - E4: down, (r B1, w B0).
  - E5: up, r B0.
  - "up" runs addresses 0..DEPTH-1; "down" runs DEPTH-1..0. The address counter wraps only between elements.
  - Total RUN length is 10*DEPTH cycles.
- Compare:
  - Read data is compared against the expected background one cycle after the read.
  - The FLUSH cycle exists to compare the final read.
- On mismatch:
  - BIST_FAIL is set (sticky).
  - BIST_FAIL_ADDR captures the address of the first failing read only.
  - The test always runs to completion.
- BIST_INJ:
  - While BIST_INJ=1, every BIST write to address 0 forces data bit 0 to 0.
  - Functional writes are unaffected.
- During RUN and FLUSH:
  - RX, TX, ADDR and DIN are ignored.
  - DVALID and ERR stay 0 and DOUT holds its last value.
  - START is ignored.

## Timing
- Read latency is 1 cycle. RX is sampled at edge N; DOUT and DVALID are valid after edge N.
- A write at edge N is readable by a read sampled at edge N+1.
- BIST handshake, with START sampled at edge E0 in IDLE or DONE:
  - BUSY=1 after E0.
  - Memory operations occur at edges E1..E(10*DEPTH).
  - FLUSH compare occurs at E(10*DEPTH+1); after that edge BUSY=0 and DONE=1.
  - For DEPTH=64, DONE rises 641 cycles after the START edge.
- Reset in any state, including mid-RUN:
  - Takes effect at that edge and aborts the test.
  - BUSY, DONE, FAIL and FAIL_ADDR go to 0.
  - Memory is left in an undefined partial-march state.
- If reset and START are both high at the same edge, reset wins and the FSM stays in IDLE.

## Test plan
- Reset: assert CoreIN_RESET for 5 cycles -> DOUT, DVALID, ERR, BUSY, DONE, FAIL and FAIL_ADDR are all 0.
- Write/read: TX with ADDR=0x2D, DIN=0x32; then RX with ADDR=0x2D -> DOUT=0x32 one cycle after the RX edge, with a single-cycle DVALID. A second read of 0x2F written with 0xA5 -> 0xA5.
- Collision and range:
  - RX=TX=1 at 0x2D -> ERR pulse, DOUT unchanged, no write.
  - With DEPTH=48, a read of ADDR=50 -> ERR pulse, DVALID=0.
- Clean BIST, DEPTH=64, BIST_INJ=0: pulse START -> BUSY high for 641 cycles, then DONE=1, FAIL=0. Functional RX/TX toggled during RUN has no effect.
- Injected fault, BIST_INJ=1: -> FAIL=1, FAIL_ADDR=0, DONE still rises at cycle 641. A subsequent write of 0xFF to address 0 followed by a read -> 0xFF.
- Reset mid-BIST: assert reset 100 cycles after START -> BUSY=0, DONE=0. Restarting BIST then completes at 641 cycles with FAIL=0.

Source files
------------

// File: rtl/ex_core_ram_bist.sv
// Single-port synchronous RAM with registered read, collision/range error pulse
// and a built-in March C- self-test engine (start/busy/done/fail handshake).
module ex_core_ram_bist #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              CLK,
    input  logic              CoreIN_RESET,
    input  logic              CoreIN_RX,
    input  logic              CoreIN_TX,
    input  logic [ADDR_W-1:0] CoreIN_ADDR,
    input  logic [DATA_W-1:0] CoreIN_DIN,
    output logic [DATA_W-1:0] CoreIN_DOUT,
    output logic              CoreIN_DVALID,
    output logic              CoreIN_ERR,
    input  logic              BIST_START,
    input  logic              BIST_INJ,
    output logic              BIST_BUSY,
    output logic              BIST_DONE,
    output logic              BIST_FAIL,
    output logic [ADDR_W-1:0] BIST_FAIL_ADDR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [2:0]        elem;
    logic              phase;
    logic [ADDR_W-1:0] addr_cnt;
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_exp;
    logic [DATA_W-1:0] cmp_data;
    logic [ADDR_W-1:0] cmp_addr;

    logic              func_mode, in_range, f_wr, f_rd, f_err;
    logic              running, down, b_rd, b_wr, rd_bg, wr_bg, at_end, step_done;
    logic [DATA_W-1:0] b_wdata;

    always_comb begin
        func_mode = (state == S_IDLE) || (state == S_DONE);
        in_range  = {1'b0, CoreIN_ADDR} < DEPTH_V;
        f_wr      = func_mode && CoreIN_TX && !CoreIN_RX && in_range;
        f_rd      = func_mode && CoreIN_RX && !CoreIN_TX && in_range;
        f_err     = func_mode && ((CoreIN_RX && CoreIN_TX) ||
                                  ((CoreIN_RX || CoreIN_TX) && !in_range));

        // E0 is write-only, E5 read-only; E1..E4 alternate read then write per address
        running   = (state == S_RUN);
        down      = (elem == 3'd3) || (elem == 3'd4);
        b_rd      = running && (elem != 3'd0) && ((elem == 3'd5) || !phase);
        b_wr      = running && (elem != 3'd5) && ((elem == 3'd0) || phase);
        rd_bg     = (elem == 3'd2) || (elem == 3'd4);
        wr_bg     = (elem == 3'd1) || (elem == 3'd3);
        at_end    = down ? (addr_cnt == '0) : (addr_cnt == LAST_ADDR);
        step_done = (elem == 3'd0) || (elem == 3'd5) || phase;

        b_wdata = {DATA_W{wr_bg}};
        if (BIST_INJ && (addr_cnt == '0)) begin
            b_wdata[0] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (f_wr) begin
            mem[CoreIN_ADDR] <= CoreIN_DIN;
        end else if (b_wr) begin
            mem[addr_cnt] <= b_wdata;
        end
        if (b_rd) begin
            cmp_data <= mem[addr_cnt];
        end
    end

    always_ff @(posedge CLK) begin
        if (CoreIN_RESET) begin
            state          <= S_IDLE;
            elem           <= '0;
            phase          <= 1'b0;
            addr_cnt       <= '0;
            cmp_valid      <= 1'b0;
            cmp_exp        <= '0;
            cmp_addr       <= '0;
            CoreIN_DOUT    <= '0;
            CoreIN_DVALID  <= 1'b0;
            CoreIN_ERR     <= 1'b0;
            BIST_FAIL      <= 1'b0;
            BIST_FAIL_ADDR <= '0;
        end else begin
            CoreIN_DVALID <= f_rd;
            CoreIN_ERR    <= f_err;
            if (f_rd) begin
                CoreIN_DOUT <= mem[CoreIN_ADDR];
            end

            cmp_valid <= b_rd;
            if (b_rd) begin
                cmp_exp  <= {DATA_W{rd_bg}};
                cmp_addr <= addr_cnt;
            end
            if (cmp_valid && (cmp_data != cmp_exp)) begin
                BIST_FAIL <= 1'b1;
                if (!BIST_FAIL) begin
                    BIST_FAIL_ADDR <= cmp_addr;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (BIST_START) begin
                        state          <= S_RUN;
                        elem           <= '0;
                        phase          <= 1'b0;
                        addr_cnt       <= '0;
                        BIST_FAIL      <= 1'b0;
                        BIST_FAIL_ADDR <= '0;
                    end
                end
                S_RUN: begin
                    if (!step_done) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!at_end) begin
                            addr_cnt <= down ? addr_cnt - ADDR_W'(1) : addr_cnt + ADDR_W'(1);
                        end else if (elem == 3'd5) begin
                            state <= S_FLUSH;
                        end else begin
                            // E3 and E4 start at the top; the others start at 0
                            elem     <= elem + 3'd1;
                            addr_cnt <= ((elem == 3'd2) || (elem == 3'd3)) ? LAST_ADDR : '0;
                        end
                    end
                end
                S_FLUSH: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BIST_BUSY = (state == S_RUN) || (state == S_FLUSH);
    assign BIST_DONE = (state == S_DONE);

endmodule

// File: tb/tb_ex_core_ram_bist.sv
// Self-checking bench: directed vector table, randomized functional traffic against
// an array-based memory model, and March C- handshake/latency/fault sequences.
module tb_ex_core_ram_bist;

    logic       CLK;
    logic       rst, rx, tx, start, inj;
    logic [5:0] addr;
    logic [7:0] din;

    logic [7:0] dout64, dout48;
    logic       dv64, dv48, err64, err48;
    logic       busy64, done64, fail64, busy48, done48, fail48;
    logic [5:0] faddr64, faddr48;
    logic       start48;

    ex_core_ram_bist #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut (
        .CLK(CLK), .CoreIN_RESET(rst), .CoreIN_RX(rx), .CoreIN_TX(tx),
        .CoreIN_ADDR(addr), .CoreIN_DIN(din), .CoreIN_DOUT(dout64),
        .CoreIN_DVALID(dv64), .CoreIN_ERR(err64), .BIST_START(start),
        .BIST_INJ(inj), .BIST_BUSY(busy64), .BIST_DONE(done64),
        .BIST_FAIL(fail64), .BIST_FAIL_ADDR(faddr64)
    );

    ex_core_ram_bist #(.DATA_W(8), .ADDR_W(6), .DEPTH(48)) dut48 (
        .CLK(CLK), .CoreIN_RESET(rst), .CoreIN_RX(rx), .CoreIN_TX(tx),
        .CoreIN_ADDR(addr), .CoreIN_DIN(din), .CoreIN_DOUT(dout48),
        .CoreIN_DVALID(dv48), .CoreIN_ERR(err48), .BIST_START(start48),
        .BIST_INJ(inj), .BIST_BUSY(busy48), .BIST_DONE(done48),
        .BIST_FAIL(fail48), .BIST_FAIL_ADDR(faddr48)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int failures = 0;

    // Behavioural model: index 0 is the 64-word instance, index 1 the 48-word one
    logic [7:0] mm  [2][64];
    bit         mk  [2][64];
    logic [7:0] md  [2];
    bit         mdk [2];
    bit         mdv [2];
    bit         merr[2];

    typedef struct {
        bit rx, tx; logic [5:0] addr; logic [7:0] din;
        bit dv; bit err; logic [7:0] dout;
        bit dv48; bit err48; logic [7:0] dout48;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? 64 : 48;
    endfunction

    task automatic model_step(input int i, input bit r, input bit t, input logic [5:0] a, input logic [7:0] d);
        mdv[i]  = 0;
        merr[i] = 0;
        if (r && t) merr[i] = 1;
        else if ((r || t) && int'(a) >= depth_of(i)) merr[i] = 1;
        else if (t) begin
            mm[i][a] = d;
            mk[i][a] = 1;
        end else if (r) begin
            md[i]  = mm[i][a];
            mdk[i] = mk[i][a];
            mdv[i] = 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md[i] = '0; mdk[i] = 1; mdv[i] = 0; merr[i] = 0;
        end
    endtask

    task automatic apply(input bit r, input bit t, input logic [5:0] a, input logic [7:0] d);
        rx = r; tx = t; addr = a; din = d;
        @(posedge CLK); #1;
        model_step(0, r, t, a, d);
        model_step(1, r, t, a, d);
    endtask

    task automatic check_func(input string tag);
        check({tag, "_dv64"},  32'(dv64),  32'(mdv[0]));
        check({tag, "_err64"}, 32'(err64), 32'(merr[0]));
        if (mdk[0]) check({tag, "_dout64"}, 32'(dout64), 32'(md[0]));
        check({tag, "_dv48"},  32'(dv48),  32'(mdv[1]));
        check({tag, "_err48"}, 32'(err48), 32'(merr[1]));
        if (mdk[1]) check({tag, "_dout48"}, 32'(dout48), 32'(md[1]));
    endtask

    // abort_at > 0 asserts reset that many cycles after the START edge
    task automatic run_bist(input bit inject, input int abort_at, input bit exp_fail);
        int n, bad;
        logic [7:0] held;
        bit held_k;
        start = 1; inj = inject; rx = 0; tx = 0;
        @(posedge CLK); #1;
        start = 0;
        model_step(1, 0, 0, addr, din);
        check("start_busy", 32'(busy64), 32'd1);
        check("start_done_clr", 32'(done64), 32'd0);
        check("start_fail_clr", 32'(fail64), 32'd0);
        held = md[0]; held_k = mdk[0];
        n = 0; bad = 0;
        while (n < 2000) begin
            rx = 1'($urandom); tx = 1'($urandom);
            addr = 6'($urandom); din = 8'($urandom);
            @(posedge CLK); #1;
            n++;
            model_step(1, rx, tx, addr, din);
            if (dv64 !== 1'b0 || err64 !== 1'b0 || (held_k && dout64 !== held)) bad++;
            if (!done64 && busy64 !== 1'b1) bad++;
            if (dv48 !== mdv[1] || err48 !== merr[1] || (mdk[1] && dout48 !== md[1])) bad++;
            if (abort_at > 0 && n == abort_at) break;
            if (done64) break;
        end
        rx = 0; tx = 0;
        check("run_quiet", 32'(bad), 32'd0);
        if (abort_at > 0) begin
            rst = 1;
            @(posedge CLK); #1;
            rst = 0;
            model_reset();
            for (int a = 0; a < 64; a++) mk[0][a] = 0;
            check("abort_busy", 32'(busy64), 32'd0);
            check("abort_done", 32'(done64), 32'd0);
            check("abort_fail", 32'(fail64), 32'd0);
            check("abort_faddr", 32'(faddr64), 32'd0);
            check("abort_dout", 32'(dout64), 32'd0);
        end else begin
            check("done_latency", 32'(n), 32'd641);
            check("done_level", 32'(done64), 32'd1);
            check("done_busy", 32'(busy64), 32'd0);
            check("bist_fail", 32'(fail64), 32'(exp_fail));
            check("bist_faddr", 32'(faddr64), 32'd0);
            for (int a = 0; a < 64; a++) begin
                mm[0][a] = '0; mk[0][a] = 1;
            end
            apply(0, 0, 0, 0);
            check("done_hold", 32'(done64), 32'd1);
            check("fail_hold", 32'(fail64), 32'(exp_fail));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; rx = 0; tx = 0; start = 0; inj = 0; addr = '0; din = '0; start48 = 0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 64; a++) begin
                mm[i][a] = '0; mk[i][a] = 0;
            end
        for (int c = 0; c < 5; c++) begin
            start = (c == 4);  // reset must win over a simultaneous START
            @(posedge CLK); #1;
        end
        rst = 0; start = 0;
        model_reset();
        check("rst_dout", 32'(dout64), 32'd0);
        check("rst_dvalid", 32'(dv64), 32'd0);
        check("rst_err", 32'(err64), 32'd0);
        check("rst_busy", 32'(busy64), 32'd0);
        check("rst_done", 32'(done64), 32'd0);
        check("rst_fail", 32'(fail64), 32'd0);
        check("rst_faddr", 32'(faddr64), 32'd0);

        //          rx tx addr   din    dv err dout   dv48 err48 dout48
        vecs[0]  = '{0, 1, 6'h2D, 8'h32, 0, 0, 8'h00, 0, 0, 8'h00};
        vecs[1]  = '{1, 0, 6'h2D, 8'h00, 1, 0, 8'h32, 1, 0, 8'h32};
        vecs[2]  = '{0, 1, 6'h2F, 8'hA5, 0, 0, 8'h32, 0, 0, 8'h32};
        vecs[3]  = '{1, 0, 6'h2F, 8'h00, 1, 0, 8'hA5, 1, 0, 8'hA5};
        vecs[4]  = '{1, 1, 6'h2D, 8'h77, 0, 1, 8'hA5, 0, 1, 8'hA5};
        vecs[5]  = '{1, 0, 6'h2D, 8'h00, 1, 0, 8'h32, 1, 0, 8'h32};
        vecs[6]  = '{0, 0, 6'h2D, 8'h00, 0, 0, 8'h32, 0, 0, 8'h32};
        vecs[7]  = '{0, 1, 6'h32, 8'h5A, 0, 0, 8'h32, 0, 1, 8'h32};
        vecs[8]  = '{1, 0, 6'h32, 8'h00, 1, 0, 8'h5A, 0, 1, 8'h32};
        vecs[9]  = '{0, 1, 6'h30, 8'h11, 0, 0, 8'h5A, 0, 1, 8'h32};
        vecs[10] = '{1, 0, 6'h30, 8'h00, 1, 0, 8'h11, 0, 1, 8'h32};
        vecs[11] = '{0, 1, 6'h3F, 8'hC3, 0, 0, 8'h11, 0, 1, 8'h32};
        vecs[12] = '{1, 0, 6'h3F, 8'h00, 1, 0, 8'hC3, 0, 1, 8'h32};
        for (int v = 0; v < 13; v++) begin
            apply(vecs[v].rx, vecs[v].tx, vecs[v].addr, vecs[v].din);
            check($sformatf("vec%0d_dv", v), 32'(dv64), 32'(vecs[v].dv));
            check($sformatf("vec%0d_err", v), 32'(err64), 32'(vecs[v].err));
            check($sformatf("vec%0d_dout", v), 32'(dout64), 32'(vecs[v].dout));
            check($sformatf("vec%0d_dv48", v), 32'(dv48), 32'(vecs[v].dv48));
            check($sformatf("vec%0d_err48", v), 32'(err48), 32'(vecs[v].err48));
            check($sformatf("vec%0d_dout48", v), 32'(dout48), 32'(vecs[v].dout48));
        end

        run_bist(0, 0, 0);

        for (int c = 0; c < 200; c++) begin
            apply(1'($urandom), 1'($urandom), 6'($urandom_range(0, 63)), 8'($urandom));
            check_func("rand");
        end

        run_bist(1, 0, 1);
        apply(0, 1, 6'h00, 8'hFF);
        check_func("inj_wr");
        apply(1, 0, 6'h00, 8'h00);
        check_func("inj_rd");
        check("inj_func_ff", 32'(dout64), 32'hFF);
        inj = 0;

        run_bist(0, 0, 0);
        run_bist(0, 100, 0);
        run_bist(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
